// File: rtl/cdc_pkg.sv
// Shared state encodings for the cdc_hs_bus 4-phase handshake.
package cdc_pkg;

    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_REQ  = 2'd1,
        A_REL  = 2'd2
    } cdc_hs_a_st_t;

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_VALID = 2'd1,
        B_ACK   = 2'd2
    } cdc_hs_b_st_t;

endpackage

// File: rtl/cdc_2ff_sync.sv
// Two-flop level synchroniser for single-bit control crossing into clk_i.
module cdc_2ff_sync #(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);

    (* async_reg = "true" *) logic [DATA_WIDTH-1:0] meta_q;
    (* async_reg = "true" *) logic [DATA_WIDTH-1:0] sync_q;

    // First stage may go metastable; second stage gives it a full cycle to settle.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cdc_hs_bus.sv
// 4-phase req/ack bus moving one DATA_WIDTH word from clk_a_in to clk_b_in.
// Optional A-side transfer counter (xfer_cnt_a_o) enabled by defining CDC_HS_XFER_CNT_EN.
module cdc_hs_bus #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_a_in,
    input  logic                  arst_a,
    input  logic                  clk_b_in,
    input  logic                  arst_b,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    input  logic                  valid_a_i,
    output logic                  ready_a_o,
    output logic                  busy_a_o,
    output logic [DATA_WIDTH-1:0] data_b_o,
    output logic                  valid_b_o,
    input  logic                  ready_b_i
`ifdef CDC_HS_XFER_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  xfer_cnt_a_o
`endif
);

    import cdc_pkg::*;

    cdc_hs_a_st_t          state_a_d, state_a_q;
    logic                  req_a_d, req_a_q;
    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic                  ack_sync_a_s;
    logic                  ready_a_s;

    cdc_hs_b_st_t          state_b_d, state_b_q;
    logic                  ack_b_d, ack_b_q;
    logic                  valid_b_d, valid_b_q;
    logic [DATA_WIDTH-1:0] data_b_d, data_b_q;
    logic                  req_sync_b_s;

    cdc_2ff_sync #(.DATA_WIDTH(1)) u_req_sync (
        .clk_i  (clk_b_in),
        .arst_i (arst_b),
        .d_i    (req_a_q),
        .q_o    (req_sync_b_s)
    );

    cdc_2ff_sync #(.DATA_WIDTH(1)) u_ack_sync (
        .clk_i  (clk_a_in),
        .arst_i (arst_a),
        .d_i    (ack_b_q),
        .q_o    (ack_sync_a_s)
    );

    // A stays closed while a stale ack is still visible, so handshakes never overlap.
    assign ready_a_s = (state_a_q == A_IDLE) && !ack_sync_a_s;
    assign ready_a_o = ready_a_s;
    assign busy_a_o  = ~ready_a_s;

    // A-side sequencing: capture on accept, hold req until ack, then wait for ack release.
    always_comb begin
        state_a_d = state_a_q;
        req_a_d   = req_a_q;
        data_d    = data_q;
        case (state_a_q)
            A_IDLE: begin
                if (valid_a_i && ready_a_s) begin
                    data_d    = data_a_i;
                    req_a_d   = 1'b1;
                    state_a_d = A_REQ;
                end else begin
                    state_a_d = A_IDLE;
                end
            end
            A_REQ: begin
                if (ack_sync_a_s) begin
                    req_a_d   = 1'b0;
                    state_a_d = A_REL;
                end else begin
                    state_a_d = A_REQ;
                end
            end
            A_REL: begin
                if (!ack_sync_a_s) begin
                    state_a_d = A_IDLE;
                end else begin
                    state_a_d = A_REL;
                end
            end
            default: begin
                state_a_d = A_IDLE;
                req_a_d   = 1'b0;
            end
        endcase
    end

    // A-side state, request and held payload registers.
    always_ff @(posedge clk_a_in or posedge arst_a) begin
        if (arst_a) begin
            state_a_q <= A_IDLE;
            req_a_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            state_a_q <= state_a_d;
            req_a_q   <= req_a_d;
            data_q    <= data_d;
        end
    end

`ifdef CDC_HS_XFER_CNT_EN
    logic [CNT_WIDTH-1:0] xfer_cnt_d, xfer_cnt_q;

    // A transfer counts once the handshake has fully returned to zero; wraps naturally.
    always_comb begin
        if ((state_a_q == A_REL) && !ack_sync_a_s) begin
            xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(1);
        end else begin
            xfer_cnt_d = xfer_cnt_q;
        end
    end

    // Transfer counter register.
    always_ff @(posedge clk_a_in or posedge arst_a) begin
        if (arst_a) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt_a_o = xfer_cnt_q;
`else
    // Without the counter CNT_WIDTH is only carried for interface compatibility.
    if (CNT_WIDTH < 1) begin : g_cnt_width_unused
    end
`endif

    // B-side sequencing; data_q is quasi-static while req is seen, so it is sampled directly.
    always_comb begin
        state_b_d = state_b_q;
        ack_b_d   = ack_b_q;
        valid_b_d = valid_b_q;
        data_b_d  = data_b_q;
        case (state_b_q)
            B_IDLE: begin
                if (req_sync_b_s) begin
                    data_b_d  = data_q;
                    valid_b_d = 1'b1;
                    state_b_d = B_VALID;
                end else begin
                    state_b_d = B_IDLE;
                end
            end
            B_VALID: begin
                if (ready_b_i) begin
                    valid_b_d = 1'b0;
                    ack_b_d   = 1'b1;
                    state_b_d = B_ACK;
                end else begin
                    state_b_d = B_VALID;
                end
            end
            B_ACK: begin
                if (!req_sync_b_s) begin
                    ack_b_d   = 1'b0;
                    state_b_d = B_IDLE;
                end else begin
                    state_b_d = B_ACK;
                end
            end
            default: begin
                state_b_d = B_IDLE;
                ack_b_d   = 1'b0;
                valid_b_d = 1'b0;
            end
        endcase
    end

    // B-side state, ack and delivered-word registers.
    always_ff @(posedge clk_b_in or posedge arst_b) begin
        if (arst_b) begin
            state_b_q <= B_IDLE;
            ack_b_q   <= 1'b0;
            valid_b_q <= 1'b0;
            data_b_q  <= '0;
        end else begin
            state_b_q <= state_b_d;
            ack_b_q   <= ack_b_d;
            valid_b_q <= valid_b_d;
            data_b_q  <= data_b_d;
        end
    end

    assign valid_b_o = valid_b_q;
    assign data_b_o  = data_b_q;

endmodule

// File: tb/tb_cdc_hs_bus.sv
// Directed self-checking bench for cdc_hs_bus (define CDC_HS_XFER_CNT_EN to cover the counter).
module tb_cdc_hs_bus;

    localparam int DW = 32;
`ifdef CDC_HS_XFER_CNT_EN
    localparam int CW = 4;
    logic [CW-1:0] xfer_cnt_a_o;
`else
    localparam int CW = 16;
`endif

    logic          clk_a_in  = 1'b0;
    logic          clk_b_in  = 1'b0;
    logic          arst_a    = 1'b1;
    logic          arst_b    = 1'b1;
    logic [DW-1:0] data_a_i  = '0;
    logic          valid_a_i = 1'b0;
    logic          ready_a_o;
    logic          busy_a_o;
    logic [DW-1:0] data_b_o;
    logic          valid_b_o;
    logic          ready_b_i = 1'b0;

    int half_a = 5;
    int half_b = 13;

    int n_total = 0;
    int n_bad   = 0;

    logic [DW-1:0] rx_q[$];
    int   vrise = 0;
    int   vhigh = 0;
    logic vprev = 1'b0;

    cdc_hs_bus #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_a_in  (clk_a_in),
        .arst_a    (arst_a),
        .clk_b_in  (clk_b_in),
        .arst_b    (arst_b),
        .data_a_i  (data_a_i),
        .valid_a_i (valid_a_i),
        .ready_a_o (ready_a_o),
        .busy_a_o  (busy_a_o),
        .data_b_o  (data_b_o),
        .valid_b_o (valid_b_o),
        .ready_b_i (ready_b_i)
`ifdef CDC_HS_XFER_CNT_EN
        ,
        .xfer_cnt_a_o (xfer_cnt_a_o)
`endif
    );

    always #(half_a) clk_a_in = ~clk_a_in;
    always #(half_b) clk_b_in = ~clk_b_in;

    // B-side monitor: valid rises, valid-high cycles, and words consumed at the next edge.
    always @(negedge clk_b_in) begin
        if (valid_b_o && !vprev) vrise++;
        if (valid_b_o) vhigh++;
        if (valid_b_o && ready_b_i) rx_q.push_back(data_b_o);
        vprev = valid_b_o;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a word and hold valid until it is accepted; returns just after the accepting edge.
    task automatic send(input logic [DW-1:0] w);
        bit ok;
        ok = 1'b0;
        @(posedge clk_a_in); #1;
        data_a_i  = w;
        valid_a_i = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_a_in);
            if (ready_a_o) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept", 64'(ok), 64'd1);
        @(posedge clk_a_in); #1;
    endtask

    task automatic wait_rx(input int n, input string tag);
        for (int k = 0; k < 6000 && rx_q.size() < n; k++) @(negedge clk_b_in);
        chk(tag, 64'(rx_q.size()), 64'(n));
    endtask

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 3000 && !ready_a_o; k++) @(negedge clk_a_in);
        chk(tag, 64'(ready_a_o), 64'd1);
    endtask

    task automatic wait_valid(input string tag);
        @(negedge clk_b_in);
        for (int k = 0; k < 3000 && !valid_b_o; k++) @(negedge clk_b_in);
        chk(tag, 64'(valid_b_o), 64'd1);
    endtask

    task automatic set_ready_b(input logic v);
        @(posedge clk_b_in); #1;
        ready_b_i = v;
    endtask

    task automatic stream(input int n, input string tag);
        int base;
        base = rx_q.size();
        for (int i = 0; i < n; i++) send(DW'(i));
        valid_a_i = 1'b0;
        wait_rx(base + n, {tag, "_count"});
        for (int i = 0; i < n; i++) begin
            if (base + i < rx_q.size()) chk({tag, "_word"}, 64'(rx_q[base + i]), 64'(i));
        end
        wait_ready({tag, "_idle"});
    endtask

    initial begin
        int r0, h0, n0, nv, ng, nr;
        bit seen;

        // Reset state
        repeat (4) @(posedge clk_a_in);
        repeat (2) @(posedge clk_b_in);
        #1;
        arst_a = 1'b0;
        arst_b = 1'b0;
        @(negedge clk_a_in);
        chk("rst_ready_a", 64'(ready_a_o), 64'd1);
        chk("rst_busy_a", 64'(busy_a_o), 64'd0);
        chk("rst_valid_b", 64'(valid_b_o), 64'd0);
        chk("rst_data_b", 64'(data_b_o), 64'd0);
`ifdef CDC_HS_XFER_CNT_EN
        chk("rst_cnt", 64'(xfer_cnt_a_o), 64'd0);
`endif

        // 1: single word, consumer always ready
        set_ready_b(1'b1);
        r0 = vrise; h0 = vhigh; n0 = rx_q.size();
        send(32'hDEAD_BEEF);
        valid_a_i = 1'b0;
        @(negedge clk_a_in);
        chk("t1_busy_after_accept", 64'(busy_a_o), 64'd1);
        wait_rx(n0 + 1, "t1_rx_count");
        wait_ready("t1_ready_back");
        chk("t1_busy_clear", 64'(busy_a_o), 64'd0);
        chk("t1_data", 64'(rx_q[n0]), 64'hDEAD_BEEF);
        chk("t1_one_pulse", 64'(vrise - r0), 64'd1);
        chk("t1_valid_width", 64'(vhigh - h0), 64'd1);

        // 2: consumer stalls 50 cycles; second word back-pressured
        set_ready_b(1'b0);
        r0 = vrise; n0 = rx_q.size();
        send(32'h0000_0001);
        data_a_i = 32'h0000_0002;
        wait_valid("t2_valid_seen");
        nv = 0; ng = 0; nr = 0;
        for (int i = 0; i < 50; i++) begin
            if (valid_b_o) nv++;
            if (data_b_o == 32'h0000_0001) ng++;
            if (ready_a_o) nr++;
            @(negedge clk_b_in);
        end
        chk("t2_valid_held", 64'(nv), 64'd50);
        chk("t2_data_held", 64'(ng), 64'd50);
        chk("t2_ready_a_low", 64'(nr), 64'd0);
        chk("t2_not_consumed", 64'(rx_q.size()), 64'(n0));
        set_ready_b(1'b1);
        send(32'h0000_0002);
        valid_a_i = 1'b0;
        wait_rx(n0 + 2, "t2_rx_count");
        chk("t2_first", 64'(rx_q[n0]), 64'd1);
        chk("t2_second", 64'(rx_q[n0 + 1]), 64'd2);
        chk("t2_pulses", 64'(vrise - r0), 64'd2);
        wait_ready("t2_idle");

        // 3: valid held high, 100 words each way round in clock ratio
        r0 = vrise;
        half_a = 5; half_b = 14;
        stream(100, "t3a");
        half_a = 14; half_b = 5;
        stream(100, "t3b");
        chk("t3_no_dup", 64'(vrise - r0), 64'd200);
        half_a = 5; half_b = 13;

        // 4: arst_a during A_REQ; B still delivers the word it already holds
        set_ready_b(1'b0);
        r0 = vrise; n0 = rx_q.size();
        send(32'hA5A5_0004);
        valid_a_i = 1'b0;
        wait_valid("t4_valid_seen");
        @(posedge clk_a_in); #1;
        arst_a = 1'b1;
        repeat (2) @(posedge clk_a_in);
        #1;
        arst_a = 1'b0;
        @(negedge clk_a_in);
        chk("t4_ready_no_ack", 64'(ready_a_o), 64'd1);
        chk("t4_valid_kept", 64'(valid_b_o), 64'd1);
        chk("t4_data_kept", 64'(data_b_o), 64'hA5A5_0004);
        set_ready_b(1'b1);
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk_a_in);
            if (!ready_a_o) seen = 1'b1;
        end
        chk("t4_blocked_by_ack", 64'(seen), 64'd1);
        wait_ready("t4_ready_back");
        repeat (20) @(negedge clk_b_in);
        chk("t4_rx_count", 64'(rx_q.size()), 64'(n0 + 1));
        chk("t4_data", 64'(rx_q[n0]), 64'hA5A5_0004);
        chk("t4_once", 64'(vrise - r0), 64'd1);

        // 5: arst_b in B_VALID with req still high -> word redelivered
        set_ready_b(1'b0);
        r0 = vrise; n0 = rx_q.size();
        send(32'h5A5A_0005);
        valid_a_i = 1'b0;
        wait_valid("t5_valid_seen");
        @(posedge clk_b_in); #1;
        arst_b = 1'b1;
        @(negedge clk_b_in);
        chk("t5_valid_cleared", 64'(valid_b_o), 64'd0);
        @(posedge clk_b_in); #1;
        arst_b = 1'b0;
        wait_valid("t5_redelivered");
        chk("t5_redeliver_data", 64'(data_b_o), 64'h5A5A_0005);
        set_ready_b(1'b1);
        wait_rx(n0 + 1, "t5_rx_count");
        wait_ready("t5_idle");
        chk("t5_data", 64'(rx_q[n0]), 64'h5A5A_0005);
        chk("t5_two_pulses", 64'(vrise - r0), 64'd2);

`ifdef CDC_HS_XFER_CNT_EN
        // 6: 17 transfers through a 4-bit counter wrap to 1
        @(posedge clk_a_in); #1;
        arst_a = 1'b1;
        @(posedge clk_a_in); #1;
        arst_a = 1'b0;
        @(negedge clk_a_in);
        chk("t6_cnt_reset", 64'(xfer_cnt_a_o), 64'd0);
        stream(17, "t6");
        chk("t6_cnt_wrap", 64'(xfer_cnt_a_o), 64'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
